// File: rtl/vga_frame_transmitter_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, also consumed by the
// colorspace converter on the receive side.
package vga_frame_transmitter_pkg;

    localparam int VGA_PIXEL_DEPTH    = 24;
    localparam int VGA_SUBPIXEL_DEPTH = VGA_PIXEL_DEPTH / 3;

    localparam int VGA_HACT = 640;
    localparam int VGA_HFP  = 16;
    localparam int VGA_HSW  = 96;
    localparam int VGA_HBP  = 48;
    localparam int VGA_HTOTAL = VGA_HACT + VGA_HFP + VGA_HSW + VGA_HBP;

    localparam int VGA_VACT = 480;
    localparam int VGA_VFP  = 10;
    localparam int VGA_VSH  = 2;
    localparam int VGA_VBP  = 33;
    localparam int VGA_VTOTAL = VGA_VACT + VGA_VFP + VGA_VSH + VGA_VBP;

    localparam int VGA_FIFO_DEPTH = 4;

    // True when pos lies in [start, start+len).
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_frame_transmitter_pixel_fifo.sv
// Small synchronous FIFO for the grayscale pixel stream; flush empties it
// in one cycle without touching the storage array.
module pixel_fifo
    import vga_frame_transmitter_pkg::*;
#(
    parameter  int P_DEPTH = VGA_FIFO_DEPTH,
    parameter  int P_WIDTH = VGA_SUBPIXEL_DEPTH,
    localparam int A_W     = $clog2(P_DEPTH),
    localparam int C_W     = A_W + 1
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               flush,
    input  logic               push,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty,
    output logic [C_W-1:0]     count
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [A_W-1:0]     wr_ptr;
    logic [A_W-1:0]     rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        full    = (count == C_W'(P_DEPTH));
        empty   = (count == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        rd_data = mem[rd_ptr];
    end

    always_ff @(posedge I_CLK) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + A_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + A_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + C_W'(1);
                2'b01:   count <= count - C_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_transmitter.sv
// VGA transmit end: free-running 640x480 timing, grayscale pixels pulled
// from a small FIFO and replicated into R, G and B.
module vga_frame_transmitter
    import vga_frame_transmitter_pkg::*;
#(
    parameter  int P_PIXEL_DEPTH     = VGA_PIXEL_DEPTH,
    parameter  int P_HACT            = VGA_HACT,
    parameter  int P_HFP             = VGA_HFP,
    parameter  int P_HSW             = VGA_HSW,
    parameter  int P_HBP             = VGA_HBP,
    parameter  int P_VACT            = VGA_VACT,
    parameter  int P_VFP             = VGA_VFP,
    parameter  int P_VSH             = VGA_VSH,
    parameter  int P_VBP             = VGA_VBP,
    parameter  bit P_SYNC_ACTIVE_LOW = 1'b1,
    parameter  int P_FIFO_DEPTH      = VGA_FIFO_DEPTH,
    localparam int P_SUBPIXEL_DEPTH  = P_PIXEL_DEPTH / 3,
    localparam int P_HTOTAL          = P_HACT + P_HFP + P_HSW + P_HBP,
    localparam int P_VTOTAL          = P_VACT + P_VFP + P_VSH + P_VBP,
    localparam int COL_W             = $clog2(P_HACT),
    localparam int ROW_W             = $clog2(P_VACT)
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic                        I_ENABLE,
    input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                        I_PIXEL_VALID,
    output logic                        O_PIXEL_READY,
    output logic [P_PIXEL_DEPTH-1:0]    O_PIXEL,
    output logic                        O_HSYNC,
    output logic                        O_VSYNC,
    output logic                        O_DATA_ENABLE,
    output logic [COL_W-1:0]            O_PIXEL_COLUMN,
    output logic [ROW_W-1:0]            O_PIXEL_ROW,
    output logic                        O_FRAME_START,
    output logic                        O_UNDERFLOW
);

    localparam int   H_W       = $clog2(P_HTOTAL);
    localparam int   V_W       = $clog2(P_VTOTAL);
    localparam int   CNT_W     = $clog2(P_FIFO_DEPTH) + 1;
    localparam logic SYNC_IDLE = P_SYNC_ACTIVE_LOW;

    logic [H_W-1:0]              h_cnt;
    logic [V_W-1:0]              v_cnt;
    logic                        active;
    logic                        hsync_on;
    logic                        vsync_on;
    logic                        frame_origin;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_flush;
    logic [P_SUBPIXEL_DEPTH-1:0] fifo_data;
    logic [CNT_W-1:0]            fifo_count;

    always_comb begin
        active       = (int'(h_cnt) < P_HACT) && (int'(v_cnt) < P_VACT);
        hsync_on     = in_window(int'(h_cnt), P_HACT + P_HFP, P_HSW);
        vsync_on     = in_window(int'(v_cnt), P_VACT + P_VFP, P_VSH);
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    // Ready looks only at the current occupancy; a pop this cycle does not free a slot.
    assign O_PIXEL_READY = I_ENABLE && (fifo_count < CNT_W'(P_FIFO_DEPTH));
    assign fifo_push     = I_PIXEL_VALID && O_PIXEL_READY && !fifo_full;
    assign fifo_pop      = I_ENABLE && active && !fifo_empty;
    assign fifo_flush    = !I_ENABLE;

    pixel_fifo #(
        .P_DEPTH (P_FIFO_DEPTH),
        .P_WIDTH (P_SUBPIXEL_DEPTH)
    ) u_pixel_fifo (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wr_data (I_PIXEL),
        .pop     (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!I_ENABLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_W'(P_HTOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_W'(P_VTOTAL - 1)) ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Output registers follow the counters by one cycle; underflow survives disable.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            O_DATA_ENABLE  <= 1'b0;
            O_HSYNC        <= SYNC_IDLE;
            O_VSYNC        <= SYNC_IDLE;
            O_PIXEL        <= '0;
            O_PIXEL_COLUMN <= '0;
            O_PIXEL_ROW    <= '0;
            O_FRAME_START  <= 1'b0;
            O_UNDERFLOW    <= 1'b0;
        end else if (!I_ENABLE) begin
            O_DATA_ENABLE  <= 1'b0;
            O_HSYNC        <= SYNC_IDLE;
            O_VSYNC        <= SYNC_IDLE;
            O_PIXEL        <= '0;
            O_PIXEL_COLUMN <= '0;
            O_PIXEL_ROW    <= '0;
            O_FRAME_START  <= 1'b0;
        end else begin
            O_DATA_ENABLE  <= active;
            O_HSYNC        <= hsync_on ? ~SYNC_IDLE : SYNC_IDLE;
            O_VSYNC        <= vsync_on ? ~SYNC_IDLE : SYNC_IDLE;
            O_PIXEL        <= fifo_pop ? {3{fifo_data}} : '0;
            O_PIXEL_COLUMN <= active ? h_cnt[COL_W-1:0] : '0;
            O_PIXEL_ROW    <= active ? v_cnt[ROW_W-1:0] : '0;
            O_FRAME_START  <= frame_origin;
            if (active && fifo_empty) begin
                O_UNDERFLOW <= 1'b1;
            end
        end
    end

endmodule
